ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1_000_000, which sets the ACK wait limit in clk cycles after each transmitted byte completes.
REQ-002 SHALL have parameter BAT_CYCLES, default 24'd16_000_000, which sets the wait limit for the 0xAA self-test byte after the reset command is acknowledged.
REQ-003 SHALL have parameter MAX_RETRY, default 2'd3, which sets the maximum number of resends per byte.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- host_tx_data  out  8  byte to transmit.
- host_tx_req  out  1  level request; a rising edge starts a transmit.
- host_tx_ready  in  1  one-cycle pulse when the device ACK bit is detected.
- host_rx_data  in  8  received byte.
- host_rx_ready  in  1  one-cycle pulse when host_rx_data is valid.
- led_state  in  3  {caps, num, scroll}.
- led_update  in  1  one-cycle request to send led_state.
- cmd_valid  in  1  user command byte valid.
- cmd_byte  in  8  user command byte.
- cmd_ready  out  1  command accepted when cmd_valid=1 in the same cycle.
- key_valid  out  1  one-cycle pulse; key_code is valid.
- key_code  out  8  forwarded device byte.
- init_done  out  1  the keyboard has passed reset and BAT.
- err  out  1  sticky failure flag.
- err_clr  in  1  clears err.

Function
REQ-005 FSM states SHALL be: INIT_SEND, INIT_ACK, INIT_BAT, IDLE, SEND, WAIT_TXD, WAIT_ACK.
REQ-006 SEND SHALL drive host_tx_data, raise host_tx_req, and go to WAIT_TXD; host_tx_req SHALL stay high until host_tx_ready, then drop in the following cycle.
REQ-007 WAIT_TXD SHALL, on host_tx_ready, load the timeout counter with TIMEOUT_CYCLES-1 and go to WAIT_ACK.
REQ-008 host_tx_req SHALL be low for at least 2 cycles between consecutive transmits.
REQ-009 In WAIT_ACK, a received 0xFA SHALL advance the sequence, with no key_valid pulse.
REQ-010 In WAIT_ACK, a received 0xFE, or the counter reaching 0, SHALL count as a failure.
REQ-011 In WAIT_ACK, any other received byte SHALL be forwarded as key_valid/key_code, and the wait SHALL continue with the counter running.
REQ-012 On a failure with retry count < MAX_RETRY, the controller SHALL increment the retry count and resend the same byte via SEND.
REQ-013 Otherwise a failure SHALL abandon the sequence. During init it SHALL restart INIT_SEND with the retry count cleared. Outside init it SHALL set err and return to IDLE.
REQ-014 The retry count SHALL clear when each new byte is loaded.
REQ-015 Init sequence: send 0xFF, expect 0xFA, enter INIT_BAT with the counter at BAT_CYCLES-1; 0xAA SHALL set init_done=1 and go to IDLE.
REQ-016 In INIT_BAT, 0xFC or timeout SHALL restart INIT_SEND; other bytes SHALL be discarded.
REQ-017 init_done SHALL, once set, stay 1 until reset.
REQ-018 led_update SHALL set a pending flag and latch led_state at any time; a later update before service SHALL overwrite the latched value.
REQ-019 In IDLE, a pending LED update SHALL have priority over cmd_valid.
REQ-020 LED sequence: send 0xED, await ACK, send {5'b0, latched leds}, await ACK, clear the pending flag, go to IDLE.
REQ-021 If led_update arrives while the LED sequence is running, the pending flag SHALL remain set and a new sequence SHALL start afterwards.
REQ-022 cmd_ready SHALL equal (state==IDLE) & init_done & ~led_pending.
REQ-023 On a cmd handshake, the controller SHALL send cmd_byte and await ACK; bytes following the ACK SHALL be forwarded as keys from IDLE.
REQ-024 In IDLE, every host_rx_ready SHALL produce key_valid=1 for exactly 1 cycle, with key_code=host_rx_data, registered with 1-cycle latency.
REQ-025 host_rx_ready and host_tx_ready asserted in the same cycle SHALL both be processed in that cycle.
REQ-026 err_clr SHALL clear err; if a set event and err_clr occur in the same cycle, set SHALL win.
REQ-027 The timeout counter SHALL be 24 bits and SHALL hold at 0 (no wrap).

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously go to INIT_SEND with host_tx_req=0, host_tx_data=0x00, key_valid=0, key_code=0x00, init_done=0, cmd_ready=0, err=0, retry count=0, led_pending=0, counter=0.
REQ-029 The first transmit (0xFF) after rst_n deasserts SHALL begin within 2 cycles.
REQ-030 Reset asserted mid-transmit SHALL drop host_tx_req immediately and restart init.

Verification
REQ-031 Reset release; model responds tx_ready, then 0xFA, then 0xAA -> init_done=1, cmd_ready=1, no key_valid pulses.
REQ-032 In IDLE, rx bytes 0x1C, 0xF0, 0x1C -> three key_valid pulses with codes 0x1C, 0xF0, 0x1C in order.
REQ-033 led_update with led_state=3'b101, and cmd_valid in the same cycle -> tx 0xED then 0x05, each ACKed; cmd_ready=0 until done; the cmd byte is then sent.
REQ-034 Command 0xEE answered 0xFE, 0xFE, 0xFA -> 0xEE transmitted 3 times; err stays 0.
REQ-035 Command with no ACK (TIMEOUT_CYCLES=100 in the bench) -> 4 transmits, err=1; err_clr -> err=0; cmd_ready=1.
REQ-036 During WAIT_ACK, rx 0x2A then 0xFA -> key_valid for 0x2A only; the sequence completes.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard host controller: sequences keyboard reset/BAT, LED updates and
// user commands over a byte-level PS/2 PHY, handling ACK/resend/timeout with
// bounded retries, and forwards unsolicited device bytes as key codes.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   host_tx_data/req/ready      byte transmit towards the PHY (req level, ready = ACK bit seen)
//   host_rx_data/ready          byte received from the PHY
//   led_state/led_update        {caps,num,scroll} update request
//   cmd_valid/cmd_byte/cmd_ready user command handshake
//   key_valid/key_code          forwarded device bytes
//   init_done, err/err_clr      init status, sticky failure flag and its clear
module ps2_kbd_ctrl #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter logic [23:0] BAT_CYCLES     = 24'd16_000_000,
    parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] host_tx_data,
    output logic       host_tx_req,
    input  logic       host_tx_ready,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_ready,
    input  logic [2:0] led_state,
    input  logic       led_update,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       init_done,
    output logic       err,
    input  logic       err_clr
);

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [2:0] {
        INIT_SEND, INIT_ACK, INIT_BAT, IDLE, SEND, WAIT_TXD, WAIT_ACK
    } state_e;

    // Which byte of which sequence is in flight outside init
    typedef enum logic [1:0] {PH_LED_CMD, PH_LED_VAL, PH_USER} phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  host_tx_data_q, host_tx_data_d;
    logic        host_tx_req_q, host_tx_req_d;
    logic        key_valid_q, key_valid_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic [1:0]  retry_q, retry_d;
    logic        led_pending_q, led_pending_d;
    logic [2:0]  led_val_q, led_val_d;
    logic [23:0] cnt_q, cnt_d;

    logic        led_pending_c;
    logic [23:0] cnt_dec_c;
    logic        rx_ack_c, rx_resend_c, fwd_c, err_set_c;

    // An update arriving this cycle already counts as pending for arbitration
    assign led_pending_c = led_pending_q | led_update;
    assign cmd_ready     = (state_q == IDLE) & init_done_q & ~led_pending_c;
    assign cnt_dec_c     = (cnt_q != 24'd0) ? cnt_q - 24'd1 : cnt_q;
    assign rx_ack_c      = host_rx_ready & (host_rx_data == RSP_ACK);
    assign rx_resend_c   = host_rx_ready & (host_rx_data == RSP_RESEND);

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        host_tx_data_d = host_tx_data_q;
        host_tx_req_d  = host_tx_req_q;
        key_valid_d    = 1'b0;
        key_code_d     = key_code_q;
        init_done_d    = init_done_q;
        err_d          = err_q;
        retry_d        = retry_q;
        led_pending_d  = led_pending_q;
        led_val_d      = led_val_q;
        cnt_d          = cnt_q;
        fwd_c          = 1'b0;
        err_set_c      = 1'b0;

        if (led_update) begin
            led_pending_d = 1'b1;
            led_val_d     = led_state;
        end

        case (state_q)
            INIT_SEND: begin
                host_tx_data_d = CMD_RESET;
                host_tx_req_d  = 1'b1;
                state_d        = WAIT_TXD;
            end
            INIT_ACK: begin
                cnt_d = cnt_dec_c;
                if (rx_ack_c) begin
                    cnt_d   = BAT_CYCLES - 24'd1;
                    retry_d = 2'd0;
                    state_d = INIT_BAT;
                end else if (rx_resend_c || (cnt_q == 24'd0)) begin
                    // Exhausted retries restart init from a clean count
                    retry_d = (retry_q < MAX_RETRY) ? retry_q + 2'd1 : 2'd0;
                    state_d = INIT_SEND;
                end
            end
            INIT_BAT: begin
                cnt_d = cnt_dec_c;
                if (host_rx_ready && (host_rx_data == RSP_BAT_OK)) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else if ((host_rx_ready && (host_rx_data == RSP_BAT_FAIL)) ||
                             (cnt_q == 24'd0)) begin
                    retry_d = 2'd0;
                    state_d = INIT_SEND;
                end
            end
            IDLE: begin
                fwd_c = host_rx_ready;
                if (led_pending_c) begin
                    // Sequence consumes the request; later updates re-arm it
                    host_tx_data_d = CMD_SET_LED;
                    phase_d        = PH_LED_CMD;
                    retry_d        = 2'd0;
                    led_pending_d  = 1'b0;
                    state_d        = SEND;
                end else if (cmd_valid) begin
                    host_tx_data_d = cmd_byte;
                    phase_d        = PH_USER;
                    retry_d        = 2'd0;
                    state_d        = SEND;
                end
            end
            SEND: begin
                fwd_c         = host_rx_ready & init_done_q;
                host_tx_req_d = 1'b1;
                state_d       = WAIT_TXD;
            end
            WAIT_TXD: begin
                fwd_c = host_rx_ready & init_done_q;
                if (host_tx_ready) begin
                    host_tx_req_d = 1'b0;
                    cnt_d         = TIMEOUT_CYCLES - 24'd1;
                    state_d       = init_done_q ? WAIT_ACK : INIT_ACK;
                end
            end
            WAIT_ACK: begin
                cnt_d = cnt_dec_c;
                fwd_c = host_rx_ready & ~rx_ack_c & ~rx_resend_c;
                if (rx_ack_c) begin
                    if (phase_q == PH_LED_CMD) begin
                        host_tx_data_d = {5'b0, led_val_q};
                        phase_d        = PH_LED_VAL;
                        retry_d        = 2'd0;
                        state_d        = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_resend_c || (cnt_q == 24'd0)) begin
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        err_set_c = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = INIT_SEND;
        endcase

        if (fwd_c) begin
            key_valid_d = 1'b1;
            key_code_d  = host_rx_data;
        end

        // Set wins over clear
        if (err_set_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT_SEND;
            phase_q        <= PH_USER;
            host_tx_data_q <= 8'h00;
            host_tx_req_q  <= 1'b0;
            key_valid_q    <= 1'b0;
            key_code_q     <= 8'h00;
            init_done_q    <= 1'b0;
            err_q          <= 1'b0;
            retry_q        <= 2'd0;
            led_pending_q  <= 1'b0;
            led_val_q      <= 3'd0;
            cnt_q          <= 24'd0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            host_tx_data_q <= host_tx_data_d;
            host_tx_req_q  <= host_tx_req_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            init_done_q    <= init_done_d;
            err_q          <= err_d;
            retry_q        <= retry_d;
            led_pending_q  <= led_pending_d;
            led_val_q      <= led_val_d;
            cnt_q          <= cnt_d;
        end
    end

    assign host_tx_data = host_tx_data_q;
    assign host_tx_req  = host_tx_req_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign init_done    = init_done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a scripted keyboard answers transmits with
// hand-chosen responses; monitors log transmitted bytes and key pulses.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] host_tx_data;
    logic       host_tx_req;
    logic       host_tx_ready = 1'b0;
    logic [7:0] host_rx_data = 8'h00;
    logic       host_rx_ready = 1'b0;
    logic [2:0] led_state = 3'd0;
    logic       led_update = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_ready;
    logic       key_valid;
    logic [7:0] key_code;
    logic       init_done;
    logic       err;
    logic       err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_log[$];
    logic [7:0] key_log[$];
    logic       prev_req = 1'b0;
    int         low_cnt = 100;
    int         gap_viol = 0;

    ps2_kbd_ctrl #(
        .TIMEOUT_CYCLES(24'd100),
        .BAT_CYCLES    (24'd300),
        .MAX_RETRY     (2'd3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_tx_data (host_tx_data),
        .host_tx_req  (host_tx_req),
        .host_tx_ready(host_tx_ready),
        .host_rx_data (host_rx_data),
        .host_rx_ready(host_rx_ready),
        .led_state    (led_state),
        .led_update   (led_update),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .cmd_ready    (cmd_ready),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .init_done    (init_done),
        .err          (err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Log transmit starts, key pulses and the idle gap before each transmit
    always @(negedge clk) begin
        if (key_valid) key_log.push_back(key_code);
        if (host_tx_req && !prev_req) begin
            tx_log.push_back(host_tx_data);
            if (low_cnt < 2) gap_viol++;
        end
        low_cnt  = host_tx_req ? 0 : low_cnt + 1;
        prev_req = host_tx_req;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        host_rx_data  = b;
        host_rx_ready = 1'b1;
        @(posedge clk); #1;
        host_rx_ready = 1'b0;
    endtask

    // Wait for a transmit, check its byte, signal the ACK bit, optionally answer
    task automatic serve_tx(input logic [7:0] exp, input logic [7:0] resp, input bit give);
        int n = 0;
        while (host_tx_req !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tx_req_seen", 32'(host_tx_req), 1);
        if (host_tx_req === 1'b1) begin
            chk("tx_data", 32'(host_tx_data), 32'(exp));
            repeat (3) @(posedge clk);
            #1 host_tx_ready = 1'b1;
            @(posedge clk); #1;
            host_tx_ready = 1'b0;
            chk("tx_req_drop", 32'(host_tx_req), 0);
            if (give) begin
                repeat (2) @(posedge clk);
                send_rx(resp);
            end
        end
    endtask

    task automatic issue_cmd(input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Release reset and complete the keyboard reset/BAT handshake
    task automatic do_init();
        bit seen = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (host_tx_req === 1'b1) seen = 1'b1;
        end
        chk("first_tx_latency", 32'(seen), 1);
        serve_tx(8'hFF, 8'hFA, 1'b1);
        chk("init_done_before_bat", 32'(init_done), 0);
        repeat (3) @(posedge clk);
        send_rx(8'hAA);
        @(posedge clk); #1;
        chk("init_done", 32'(init_done), 1);
        chk("init_cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        int base;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_req", 32'(host_tx_req), 0);
        chk("rst_tx_data", 32'(host_tx_data), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_key_code", 32'(key_code), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_err", 32'(err), 0);

        // Reset, ACK, BAT pass
        do_init();
        chk("init_no_keys", key_log.size(), 0);

        // Scan codes in idle: 1-cycle latency, 1-cycle pulse
        send_rx(8'h1C);
        chk("key_lat_valid", 32'(key_valid), 1);
        chk("key_lat_code", 32'(key_code), 'h1C);
        @(posedge clk); #1;
        chk("key_pulse_width", 32'(key_valid), 0);
        send_rx(8'hF0);
        send_rx(8'h1C);
        @(posedge clk); #1;
        chk("idle_key_count", key_log.size(), 3);
        if (key_log.size() == 3) begin
            chk("idle_key0", 32'(key_log[0]), 'h1C);
            chk("idle_key1", 32'(key_log[1]), 'hF0);
            chk("idle_key2", 32'(key_log[2]), 'h1C);
        end

        // LED update and command in the same cycle: LED goes first
        @(posedge clk); #1;
        led_state  = 3'b101;
        led_update = 1'b1;
        cmd_byte   = 8'hF4;
        cmd_valid  = 1'b1;
        #1 chk("led_blocks_cmd", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        led_update = 1'b0;
        serve_tx(8'hED, 8'hFA, 1'b1);
        chk("cmd_ready_mid_led", 32'(cmd_ready), 0);
        serve_tx(8'h05, 8'hFA, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        serve_tx(8'hF4, 8'hFA, 1'b1);
        @(posedge clk); #1;
        chk("after_led_cmd_ready", 32'(cmd_ready), 1);

        // Update during LED sequence overwrites the value and re-runs it
        base = tx_log.size();
        led_state  = 3'b001;
        led_update = 1'b1;
        @(posedge clk); #1;
        led_update = 1'b0;
        @(posedge clk); #1;
        led_state  = 3'b010;
        led_update = 1'b1;
        @(posedge clk); #1;
        led_update = 1'b0;
        serve_tx(8'hED, 8'hFA, 1'b1);
        serve_tx(8'h02, 8'hFA, 1'b1);
        serve_tx(8'hED, 8'hFA, 1'b1);
        serve_tx(8'h02, 8'hFA, 1'b1);
        repeat (2) @(posedge clk); #1;
        chk("led_rerun_tx_count", tx_log.size() - base, 4);
        chk("led_rerun_cmd_ready", 32'(cmd_ready), 1);

        // Resend twice then ACK
        base = tx_log.size();
        issue_cmd(8'hEE);
        serve_tx(8'hEE, 8'hFE, 1'b1);
        serve_tx(8'hEE, 8'hFE, 1'b1);
        serve_tx(8'hEE, 8'hFA, 1'b1);
        repeat (2) @(posedge clk); #1;
        chk("resend_tx_count", tx_log.size() - base, 3);
        chk("resend_err", 32'(err), 0);
        chk("resend_no_keys", key_log.size(), 3);

        // Key byte interleaved before the ACK
        issue_cmd(8'hF4);
        serve_tx(8'hF4, 8'h2A, 1'b1);
        send_rx(8'hFA);
        repeat (2) @(posedge clk); #1;
        chk("interleave_key_count", key_log.size(), 4);
        if (key_log.size() == 4) chk("interleave_key", 32'(key_log[3]), 'h2A);
        chk("interleave_cmd_ready", 32'(cmd_ready), 1);

        // No ACK at all: 1 + 3 retries, then err
        base = tx_log.size();
        issue_cmd(8'hF2);
        for (int i = 0; i < 4; i++) serve_tx(8'hF2, 8'h00, 1'b0);
        repeat (150) @(posedge clk); #1;
        chk("timeout_tx_count", tx_log.size() - base, 4);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_req_idle", 32'(host_tx_req), 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 0);
        chk("err_clr_cmd_ready", 32'(cmd_ready), 1);

        // Reset in the middle of a transmit
        issue_cmd(8'hF5);
        begin
            int n = 0;
            while (host_tx_req !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midrst_req_high", 32'(host_tx_req), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req_drop", 32'(host_tx_req), 0);
        chk("midrst_init_clr", 32'(init_done), 0);
        repeat (3) @(posedge clk);
        do_init();

        chk("tx_gap", gap_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
